dot9_seq_ctrl: RTL and testbench

Sequencing controller for the 9-tap signed 8-bit multiplier array that serves as the 3x3 convolution kernel unit. It takes a serial stream of (data, weight) pairs, collects 9 of them into a window and drives one 9-wide multiplier array instance. It registers the products, reduces them with a bias into one accumulator value, applies optional ReLU, and presents the result on a valid/ready output. It sits between the line-buffer/weight fetch logic and the output writeback.

---
 rtl/dot9_seq_ctrl.sv | 107 ++++++++++
 tb/tb_dot9_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot9_seq_ctrl.sv
// dot9_seq_ctrl: gathers nine signed (data, weight) pairs, multiplies them, sums with bias, optional ReLU, valid/ready result
module dot9_seq_ctrl #(
    parameter int ACC_W = 20,
    parameter bit RELU  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       in_data,
    input  logic signed [7:0]       in_weight,
    input  logic signed [15:0]      in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_result,
    output logic                    busy
);
    typedef enum logic [1:0] {LOAD, MUL, SUM, OUT} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic signed [7:0] data_r [9];
    logic signed [7:0] weight_r [9];
    logic signed [15:0] prod_r [9];
    logic signed [15:0] bias_r;
    logic signed [ACC_W-1:0] acc;
    logic in_xfer, out_xfer, last;

    assign in_ready  = state == LOAD;
    assign out_valid = state == OUT;
    assign busy      = !(state == LOAD && cnt == 4'd0);
    assign in_xfer   = in_valid && in_ready && !clear;
    assign out_xfer  = out_valid && out_ready && !clear;
    assign last      = cnt == 4'd8;

    // next state and tap count; clear overrides any transfer
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clear) begin
            state_nx = LOAD;
            cnt_nx   = 4'd0;
        end else begin
            case (state)
                LOAD: begin
                    cnt_nx   = in_xfer ? (last ? 4'd0 : cnt + 4'd1) : cnt;
                    state_nx = (in_xfer && last) ? MUL : LOAD;
                end
                MUL:     state_nx = SUM;
                SUM:     state_nx = OUT;
                OUT:     state_nx = out_xfer ? LOAD : OUT;
                default: state_nx = LOAD;
            endcase
        end
    end

    // state and tap count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // capture each accepted pair into its slot; bias rides with the last pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                data_r[k]   <= '0;
                weight_r[k] <= '0;
            end
            bias_r <= '0;
        end else if (in_xfer) begin
            for (int k = 0; k < 9; k++) begin
                if (cnt == 4'(k)) begin
                    data_r[k]   <= in_data;
                    weight_r[k] <= in_weight;
                end
            end
            if (last) bias_r <= in_bias;
        end
    end

    // multiplier array: nine 8x8 signed products registered in MUL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) prod_r[k] <= '0;
        end else if (state == MUL && !clear) begin
            for (int k = 0; k < 9; k++) prod_r[k] <= data_r[k] * weight_r[k];
        end
    end

    // adder tree: sign-extended products plus bias
    always_comb begin
        acc = ACC_W'(bias_r);
        for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod_r[k]);
    end

    // result register loaded in SUM, held through OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_result <= '0;
        else if (state == SUM && !clear) out_result <= (RELU && acc[ACC_W-1]) ? '0 : acc;
    end
endmodule

// File: tb/tb_dot9_seq_ctrl.sv
// tb_dot9_seq_ctrl: table-driven and scoreboarded checks of dot9_seq_ctrl, RELU=0 and RELU=1 side by side
module tb_dot9_seq_ctrl;
    logic clk = 1'b0;
    logic rst, clear, in_valid, out_ready;
    logic signed [7:0] in_data, in_weight;
    logic signed [15:0] in_bias;
    logic in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic signed [19:0] out_result0, out_result1;
    int checks = 0;
    int failures = 0;
    int accepts = 0;
    int q[$];
    int e;

    typedef struct packed {
        logic [7:0]  db;
        logic        dinc;
        logic [7:0]  w;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    dot9_seq_ctrl #(.ACC_W(20), .RELU(1'b0)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_result(out_result0), .busy(busy0)
    );
    dot9_seq_ctrl #(.ACC_W(20), .RELU(1'b1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias), .out_valid(out_valid1),
        .out_ready(out_ready), .out_result(out_result1), .busy(busy1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input logic [8:0][7:0] d, input logic [8:0][7:0] w, input logic [15:0] b);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < 9; i++) s += int'($signed(d[i])) * int'($signed(w[i]));
        return s;
    endfunction

    // monitor: handshake rule, accept counting, scoreboard pop on each result transfer
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_excl", longint'(in_ready0 && out_valid0), 0);
            if (in_valid && in_ready0 && !clear) accepts++;
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("result", longint'(out_result0), longint'(e));
                    chk("relu_result", longint'(out_result1), longint'(e < 0 ? 0 : e));
                    chk("relu_valid", longint'(out_valid1), 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] w, input logic [15:0] b);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_weight = w;
        in_bias = b;
        while (!got && n < 100) begin
            @(negedge clk);
            got = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_window(input logic [8:0][7:0] d, input logic [8:0][7:0] w, input logic [15:0] b,
                               input bit gap, input bit push, input int exp);
        for (int i = 0; i < 9; i++) begin
            send(d[i], w[i], i == 8 ? b : 16'($urandom));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
        if (push) q.push_back(exp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy0 && n < 60);
        if (busy0) chk(name, 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_window(input bit gap);
        logic [8:0][7:0] d, w;
        logic [15:0] b;
        for (int i = 0; i < 9; i++) begin
            d[i] = 8'($urandom);
            w[i] = 8'($urandom);
        end
        b = 16'($urandom);
        send_window(d, w, b, gap, 1'b1, dot(d, w, b));
    endtask

    task automatic tbl_window(input int t, output logic [8:0][7:0] d, output logic [8:0][7:0] w);
        for (int i = 0; i < 9; i++) begin
            d[i] = tbl[t].db + (tbl[t].dinc ? 8'(i) : 8'd0);
            w[i] = tbl[t].w;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0][7:0] d, w;
        logic signed [19:0] held;
        int a0, n;
        tbl[0] = '{8'd1,   1'b0, 8'd1,   16'd0,    32'd9};
        tbl[1] = '{8'h80,  1'b0, 8'h80,  16'h7fff, 32'd180223};
        tbl[2] = '{8'h80,  1'b0, 8'h7f,  16'h8000, -32'sd179072};
        tbl[3] = '{8'd1,   1'b1, 8'hff,  16'd5,    -32'sd40};
        tbl[4] = '{8'd2,   1'b0, 8'd3,   16'd1,    32'd55};
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_weight = '0; in_bias = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid0), 0);
        chk("rst_out_result", longint'(out_result0), 0);
        chk("rst_busy", longint'(busy0), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready0), 1);

        for (int t = 0; t < 4; t++) begin
            tbl_window(t, d, w);
            send_window(d, w, tbl[t].b, 1'b0, 1'b1, int'($signed(tbl[t].exp)));
            if (t == 0) begin
                @(negedge clk); chk("lat_mul", longint'(out_valid0), 0);
                @(negedge clk); chk("lat_sum", longint'(out_valid0), 0);
                @(negedge clk); chk("lat_out", longint'(out_valid0), 1);
                @(negedge clk); chk("lat_drop", longint'(out_valid0), 0);
                chk("lat_in_ready", longint'(in_ready0), 1);
            end
            wait_idle("idle_timeout");
        end

        a0 = accepts;
        rand_window(1'b1);
        chk("toggle_accepts", longint'(accepts - a0), 9);
        wait_idle("idle_timeout");
        rand_window(1'b0);
        wait_idle("idle_timeout");

        out_ready = 1'b0;
        rand_window(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid0 && n < 10);
        chk("bp_valid_rise", longint'(out_valid0), 1);
        held = out_result0;
        in_valid = 1'b1;
        in_data = 8'sd99;
        in_weight = 8'sd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", longint'(out_result0), longint'(held));
            chk("bp_in_ready", longint'(in_ready0), 0);
            chk("bp_valid", longint'(out_valid0), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        wait_idle("idle_timeout");
        rand_window(1'b0);
        wait_idle("idle_timeout");

        tbl_window(4, d, w);
        for (int i = 0; i < 4; i++) send(8'd7, 8'd7, 16'd0);
        chk("partial_busy", longint'(busy0), 1);
        in_valid = 1'b1; in_data = 8'sd77; clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_idle", longint'(busy0), 0);
        send_window(d, w, tbl[4].b, 1'b0, 1'b1, int'($signed(tbl[4].exp)));
        wait_idle("idle_timeout");

        tbl_window(0, d, w);
        send_window(d, w, 16'd0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("sumrst_out_valid", longint'(out_valid0), 0);
        chk("sumrst_in_ready", longint'(in_ready0), 1);
        chk("sumrst_out_result", longint'(out_result0), 0);
        repeat (3) @(negedge clk);
        chk("sumrst_no_result", longint'(out_valid0), 0);
        @(posedge clk);
        #1;
        rand_window(1'b0);
        wait_idle("idle_timeout");

        chk("sb_drain", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
